// File: rtl/dice_roller.sv
// dice_roller: roll-button front end for the dual-dice display board.
// The raw button is synchronised and debounced. Two free-running dice
// tumble while the button is held. On release they settle over a few
// animation ticks and then latch. C1/C2/disp_en feed the 7-segment driver.
// Optional build macro: DICE_SUM_EN adds registered sum/doubles outputs.
module dice_roller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ANIM_DIV        = 2500000,
    parameter int unsigned LAND_TICKS      = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_btn,
    output logic [3:0] C1,
    output logic [3:0] C2,
    output logic       disp_en,
    output logic       rolling
`ifdef DICE_SUM_EN
    ,
    output logic [3:0] sum,
    output logic       doubles
`endif
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AN_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned LD_W = $clog2(LAND_TICKS + 1);

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AN_W-1:0] AN_MAX  = AN_W'(ANIM_DIV - 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LAND_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        LAND,
        SHOW
    } state_t;

    state_t state_q, state_d;

    logic            sync1, sync2;
    logic            btn_db, btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            db_rise, db_fall;

    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [2:0]      d1, d2;

    logic [AN_W-1:0] anim_cnt;
    logic            anim_active;
    logic            tick;
    logic            enter_roll;

    logic [LD_W-1:0] land_q, land_d;
    logic [3:0]      c1_d, c2_d;
    logic            disp_en_d, rolling_d;

    // Two-flop synchroniser, then accept a level change only after it has
    // been stable for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= roll_btn;
            sync2    <= sync1;
            btn_db_q <= btn_db;
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                btn_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign db_rise = btn_db & ~btn_db_q;
    assign db_fall = ~btn_db & btn_db_q;

    // Galois LFSR step for x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // LFSR register; a zero state would lock up, so it is reseeded.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == 16'h0000) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Free-running dice: d1 every cycle, d2 only when the LFSR lsb is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= 3'd1;
            d2 <= 3'd1;
        end else begin
            d1 <= (d1 == 3'd6) ? 3'd1 : d1 + 3'd1;
            if (lfsr[0]) begin
                d2 <= (d2 == 3'd6) ? 3'd1 : d2 + 3'd1;
            end
        end
    end

    assign anim_active = (state_q == ROLL) || (state_q == LAND);
    assign tick        = anim_active && (anim_cnt == AN_MAX);
    assign enter_roll  = (state_d == ROLL) && (state_q != ROLL);

    // Animation divider: runs only while tumbling, restarts on ROLL entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            anim_cnt <= '0;
        end else if (enter_roll) begin
            anim_cnt <= '0;
        end else if (anim_active) begin
            anim_cnt <= tick ? '0 : anim_cnt + 1'b1;
        end else begin
            anim_cnt <= '0;
        end
    end

    // Next state and next registered outputs. Outputs are derived from the
    // next state, so they change on the same edge as the state register.
    // Leaving IDLE loads the dice immediately so C1/C2 never show 0 outside
    // IDLE; entering ROLL from SHOW keeps the shown values until a tick.
    always_comb begin
        state_d = state_q;
        land_d  = land_q;
        c1_d    = C1;
        c2_d    = C2;
        case (state_q)
            IDLE: begin
                if (db_rise) begin
                    state_d = ROLL;
                    c1_d    = {1'b0, d1};
                    c2_d    = {1'b0, d2};
                end
            end
            ROLL: begin
                if (tick) begin
                    c1_d = {1'b0, d1};
                    c2_d = {1'b0, d2};
                end
                if (db_fall) begin
                    state_d = LAND;
                    land_d  = '0;
                end
            end
            LAND: begin
                if (tick) begin
                    c1_d   = {1'b0, d1};
                    c2_d   = {1'b0, d2};
                    land_d = land_q + 1'b1;
                    if (land_q == LD_LAST) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                if (db_rise) begin
                    state_d = ROLL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE) begin
            c1_d = 4'd0;
            c2_d = 4'd0;
        end
        disp_en_d = (state_d != IDLE);
        rolling_d = (state_d == ROLL) || (state_d == LAND);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            land_q  <= '0;
            C1      <= 4'd0;
            C2      <= 4'd0;
            disp_en <= 1'b0;
            rolling <= 1'b0;
        end else begin
            state_q <= state_d;
            land_q  <= land_d;
            C1      <= c1_d;
            C2      <= c2_d;
            disp_en <= disp_en_d;
            rolling <= rolling_d;
        end
    end

`ifdef DICE_SUM_EN
    // Sum and doubles flag, registered alongside C1/C2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= 4'd0;
            doubles <= 1'b0;
        end else begin
            sum     <= c1_d + c2_d;
            doubles <= (c1_d == c2_d) && (state_d == SHOW);
        end
    end
`endif

endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: directed bench for dice_roller with short debounce and
// animation periods. Define DICE_SUM_EN to also exercise sum/doubles.
module tb_dice_roller;

    logic       clk;
    logic       rst;
    logic       roll_btn;
    logic [3:0] C1, C2;
    logic       disp_en, rolling;
`ifdef DICE_SUM_EN
    logic [3:0] sum;
    logic       doubles;
`endif

    int checks   = 0;
    int failures = 0;

    dice_roller #(
        .DEBOUNCE_CYCLES(4),
        .ANIM_DIV       (3),
        .LAND_TICKS     (3),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .roll_btn(roll_btn),
        .C1      (C1),
        .C2      (C2),
        .disp_en (disp_en),
        .rolling (rolling)
`ifdef DICE_SUM_EN
        ,
        .sum     (sum),
        .doubles (doubles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference dice: free-running from reset, *_q holds the value that was
    // present before the most recent edge.
    logic [15:0] m_lfsr;
    logic [2:0]  m_d1, m_d2, m_d1_q, m_d2_q;

    always @(posedge clk) begin
        m_d1_q <= m_d1;
        m_d2_q <= m_d2;
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_d1   <= 3'd1;
            m_d2   <= 3'd1;
        end else begin
            m_d1 <= (m_d1 == 3'd6) ? 3'd1 : m_d1 + 3'd1;
            if (m_lfsr[0]) m_d2 <= (m_d2 == 3'd6) ? 3'd1 : m_d2 + 3'd1;
            if (m_lfsr == 16'h0000) m_lfsr <= 16'hACE1;
            else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_c1"}, C1, 0);
        check({tag, "_c2"}, C2, 0);
        check({tag, "_disp_en"}, disp_en, 0);
        check({tag, "_rolling"}, rolling, 0);
`ifdef DICE_SUM_EN
        check({tag, "_sum"}, sum, 0);
        check({tag, "_doubles"}, doubles, 0);
`endif
    endtask

    task automatic check_show(input string tag);
        check({tag, "_c1_range"}, int'(C1 >= 4'd1 && C1 <= 4'd6), 1);
        check({tag, "_c2_range"}, int'(C2 >= 4'd1 && C2 <= 4'd6), 1);
        check({tag, "_disp_en"}, disp_en, 1);
`ifdef DICE_SUM_EN
        check({tag, "_sum"}, sum, int'(C1) + int'(C2));
        check({tag, "_doubles"}, doubles, int'(C1 == C2));
`endif
    endtask

    // Wait for the dice to settle; the bound turns a hang into a failure.
    task automatic wait_settle();
        int n = 0;
        while (rolling && n < 60) begin
            step();
`ifdef DICE_SUM_EN
            if (rolling) check("doubles_while_rolling", doubles, 0);
`endif
            n++;
        end
        check("settle_timeout", rolling, 0);
    endtask

    task automatic do_roll(input int wait_cyc, input int hold);
        repeat (wait_cyc) step();
        roll_btn = 1'b1;
        repeat (hold) step();
        roll_btn = 1'b0;
        wait_settle();
    endtask

    bit seen1[1:6];
    bit seen2[1:6];
    int p1, p2;

    initial begin
        rst      = 1'b1;
        roll_btn = 1'b0;
        repeat (2) step();
        check_reset_vals("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_reset_vals("idle_hold");
        end

        // Short glitch must not survive the debouncer.
        roll_btn = 1'b1;
        repeat (3) step();
        roll_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("glitch_disp_en", disp_en, 0);
            check("glitch_rolling", rolling, 0);
        end

        // Press for 60 cycles, then release. Edge k counts from the press.
        // btn_db rises at edge 6, ROLL at 7, ticks at 10,13,...; release
        // drops btn_db at edge 66, landing follows after three ticks.
        p1 = 0;
        p2 = 0;
        roll_btn = 1'b1;
        for (int k = 1; k <= 76; k++) begin
            step();
            if (k <= 6) check("pre_roll_rolling", rolling, 0);
            else if (k <= 73) check("rolling_hi", rolling, 1);
            if (k == 7) check("roll_disp_en", disp_en, 1);
            if (k >= 7) begin
                check("roll_c1_range", int'(C1 >= 4'd1 && C1 <= 4'd6), 1);
                check("roll_c2_range", int'(C2 >= 4'd1 && C2 <= 4'd6), 1);
                if (k >= 10 && (k - 10) % 3 == 0) begin
                    check("tick_c1", C1, m_d1_q);
                    check("tick_c2", C2, m_d2_q);
                end else if (k >= 8) begin
                    check("hold_c1", C1, p1);
                    check("hold_c2", C2, p2);
                end
            end
            p1 = C1;
            p2 = C2;
            if (k == 60) roll_btn = 1'b0;
        end
        step();
        check("landed_rolling", rolling, 0);
        check("landed_disp_en", disp_en, 1);
        check("landed_c1", C1, p1);
        check("landed_c2", C2, p2);
        for (int i = 0; i < 100; i++) begin
            step();
            check("show_c1_stable", C1, p1);
            check("show_c2_stable", C2, p2);
            check("show_rolling", rolling, 0);
`ifdef DICE_SUM_EN
            check("show_sum", sum, p1 + p2);
            check("show_doubles", doubles, int'(p1 == p2));
`endif
        end
        check_show("first_show");

        // Many rolls with varying gap/hold so both dice visit every face.
        for (int i = 0; i < 100; i++) begin
            do_roll(1 + i % 7, 20 + i % 5);
            check_show("roll_show");
            if (C1 >= 4'd1 && C1 <= 4'd6) seen1[C1] = 1'b1;
            if (C2 >= 4'd1 && C2 <= 4'd6) seen2[C2] = 1'b1;
        end
        for (int v = 1; v <= 6; v++) begin
            check($sformatf("cover_d1_%0d", v), seen1[v], 1);
            check($sformatf("cover_d2_%0d", v), seen2[v], 1);
        end

        // Reset in the middle of ROLL.
        roll_btn = 1'b1;
        repeat (15) step();
        check("mid_roll_rolling", rolling, 1);
        rst      = 1'b1;
        roll_btn = 1'b0;
        step();
        check_reset_vals("rst_mid_roll");
        rst = 1'b0;
        do_roll(3, 20);
        check_show("after_rst_roll");

        // Reset in the middle of LAND.
        roll_btn = 1'b1;
        repeat (20) step();
        roll_btn = 1'b0;
        repeat (8) step();
        check("mid_land_rolling", rolling, 1);
        rst = 1'b1;
        step();
        check_reset_vals("rst_mid_land");
        rst = 1'b0;
        repeat (10) step();
        check_reset_vals("idle_after_rst");
        do_roll(2, 25);
        check_show("after_rst_land");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
